// File: rtl/fetch_control.sv
// Purpose: multi-cycle control FSM for a MIPS subset; latches the fetched word into IR, decodes it and
//          issues the datapath and PC-update controls, with exactly one write_pc pulse per instruction.
// Latency: 2 cycles for J/JAL/JR/illegal, 3 for BEQ/BNE, 4 for SW/R-type/ADDI/XORI, 5 for LW.
// Backpressure: none; the FSM advances every cycle and async reset aborts any instruction in flight.
module fetch_control #(
  parameter int          LINK_REG    = 31,
  parameter logic [15:0] BRANCH_BIAS = 16'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic        alu_zero,
  input  logic [31:0] rs_data,
  output logic        write_pc,
  output logic        is_branch,
  output logic        is_jump,
  output logic [15:0] branch_addr,
  output logic [31:0] jump_addr,
  output logic        reg_we,
  output logic [4:0]  reg_waddr,
  output logic [1:0]  wb_sel,
  output logic [2:0]  alu_op,
  output logic        alu_src_imm,
  output logic [31:0] imm_ext,
  output logic        mem_we,
  output logic        illegal,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t      r_state;
  logic [31:0] r_ir;

  // While in FETCH the word being latched is decoded directly, so the DECODE-cycle
  // outputs can already be registered at the same edge that loads IR.
  logic [31:0] w_ir;
  logic [5:0]  w_op;
  logic [5:0]  w_fn;
  logic        w_rtype, w_add, w_sub, w_slt, w_jr;
  logic        w_j, w_jal, w_beq, w_bne, w_lw, w_sw, w_addi, w_xori;
  logic        w_jump_cls, w_legal, w_taken, w_src_imm;
  logic [2:0]  w_alu_op;
  logic [31:0] w_imm_ext;
  logic [15:0] w_branch_addr;
  logic [4:0]  w_wb_addr;

  assign w_ir    = (r_state == S_FETCH) ? instr : r_ir;
  assign w_op    = w_ir[31:26];
  assign w_fn    = w_ir[5:0];
  assign w_rtype = (w_op == 6'h00);
  assign w_add   = w_rtype && (w_fn == 6'h20);
  assign w_sub   = w_rtype && (w_fn == 6'h22);
  assign w_slt   = w_rtype && (w_fn == 6'h2A);
  assign w_jr    = w_rtype && (w_fn == 6'h08);
  assign w_j     = (w_op == 6'h02);
  assign w_jal   = (w_op == 6'h03);
  assign w_beq   = (w_op == 6'h04);
  assign w_bne   = (w_op == 6'h05);
  assign w_addi  = (w_op == 6'h08);
  assign w_xori  = (w_op == 6'h0E);
  assign w_lw    = (w_op == 6'h23);
  assign w_sw    = (w_op == 6'h2B);

  assign w_jump_cls = w_j || w_jal || w_jr;
  assign w_legal    = w_add || w_sub || w_slt || w_jr || w_j || w_jal || w_beq || w_bne ||
                      w_addi || w_xori || w_lw || w_sw;
  assign w_taken    = w_beq ? alu_zero : !alu_zero;
  assign w_src_imm  = w_addi || w_xori || w_lw || w_sw;
  assign w_alu_op   = (w_sub || w_beq || w_bne) ? 3'd1 :
                      w_xori                    ? 3'd2 :
                      w_slt                     ? 3'd3 : 3'd0;
  assign w_imm_ext  = w_xori ? {16'h0000, w_ir[15:0]} : {{16{w_ir[15]}}, w_ir[15:0]};
  assign w_branch_addr = {w_ir[13:0], 2'b00} + BRANCH_BIAS;
  assign w_wb_addr  = w_rtype ? w_ir[15:11] : w_ir[20:16];

  assign state = r_state;

  // FSM: each edge moves to the next state and registers the outputs belonging to that
  // state; pulse outputs default low so none is ever held for a second cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_FETCH;
      r_ir        <= 32'h0;
      write_pc    <= 1'b0;
      is_branch   <= 1'b0;
      is_jump     <= 1'b0;
      branch_addr <= 16'h0;
      jump_addr   <= 32'h0;
      reg_we      <= 1'b0;
      reg_waddr   <= 5'd0;
      wb_sel      <= 2'd0;
      alu_op      <= 3'd0;
      alu_src_imm <= 1'b0;
      imm_ext     <= 32'h0;
      mem_we      <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      write_pc  <= 1'b0;
      is_branch <= 1'b0;
      is_jump   <= 1'b0;
      reg_we    <= 1'b0;
      mem_we    <= 1'b0;
      illegal   <= 1'b0;
      case (r_state)
        S_FETCH: begin
          r_ir        <= instr;
          r_state     <= S_DECODE;
          // ALU controls are presented from DECODE onward so that a branch compare is
          // already settled when the taken decision is registered into EXEC.
          alu_op      <= w_alu_op;
          alu_src_imm <= w_src_imm;
          imm_ext     <= w_imm_ext;
          branch_addr <= w_branch_addr;
          if (w_j || w_jal) begin
            jump_addr <= (pc & 32'hF000_0000) | {4'h0, w_ir[25:0], 2'b00};
            is_jump   <= 1'b1;
            write_pc  <= 1'b1;
            if (w_jal) begin
              reg_we    <= 1'b1;
              reg_waddr <= 5'(LINK_REG);
              wb_sel    <= 2'd2;
            end
          end else if (w_jr) begin
            jump_addr <= rs_data;
            is_jump   <= 1'b1;
            write_pc  <= 1'b1;
          end else if (!w_legal) begin
            illegal  <= 1'b1;
            write_pc <= 1'b1;
          end
        end
        S_DECODE: begin
          if (w_jump_cls || !w_legal) begin
            r_state <= S_FETCH;
          end else begin
            r_state <= S_EXEC;
            if (w_beq || w_bne) begin
              write_pc  <= 1'b1;
              is_branch <= w_taken;
            end
          end
        end
        S_EXEC: begin
          if (w_beq || w_bne) begin
            r_state <= S_FETCH;
          end else if (w_lw || w_sw) begin
            r_state <= S_MEM;
            if (w_sw) begin
              mem_we   <= 1'b1;
              write_pc <= 1'b1;
            end
          end else begin
            r_state   <= S_WB;
            reg_we    <= 1'b1;
            write_pc  <= 1'b1;
            reg_waddr <= w_wb_addr;
            wb_sel    <= 2'd0;
          end
        end
        S_MEM: begin
          if (w_lw) begin
            r_state   <= S_WB;
            reg_we    <= 1'b1;
            write_pc  <= 1'b1;
            reg_waddr <= w_wb_addr;
            wb_sel    <= 2'd1;
          end else begin
            r_state <= S_FETCH;
          end
        end
        S_WB:    r_state <= S_FETCH;
        default: r_state <= S_FETCH;
      endcase
    end
  end

endmodule
